fft32_stage2: RTL and testbench
===============================

Name: fft32_stage2

Overview:
- Second radix-2 single-path delay-feedback (R2SDF) DIF stage of the 32-point streaming FFT.
- Consumes the complex stream produced by stage 1 and performs butterflies with span 8.
- Multiplies the difference branch by the twiddle W16^k (= W32^2k).
- Feeds stage 3 through a registered output with a valid flag.

Parameters:
- WIDTH, 16, signed two's-complement width of each real/imag sample (in and out).
- TW_FRAC, 8, fractional bits of the twiddle ROM coefficients (signed, TW_FRAC+2 bits wide).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-high reset (held name is codebase-standard; asserted = 1 clears the block).
- valid_i  input  1  input sample valid; block state advances only when 1.
- data_in_r  input  WIDTH  real part of input sample.
- data_in_i  input  WIDTH  imaginary part of input sample.
- valid_o  output  1  output sample valid.
- data_out_r  output  WIDTH  real part of output sample.
- data_out_i  output  WIDTH  imaginary part of output sample.

Behaviour:
- Reset (rst_n=1 at a rising edge): cnt=0, primed=0, all 8 delay-line entries=0, valid_o=0, data_out_r=data_out_i=0. Takes priority over valid_i; legal mid-frame; the next valid_i after release is sample 0 of a new frame.
- cnt: 5-bit accepted-sample counter, +1 per valid_i=1 cycle, wraps 31->0. phase = cnt[3]; k = cnt[2:0].
- Delay line: 8-entry complex FIFO shift register (head = oldest). Shifts only on valid_i=1; frozen otherwise (stall-safe).
- Phase A (cnt[3]=0), on accepted sample:
  - push x_in into the delay line.
  - output candidate = head * W16^k (pending difference d_k of the previous half-block).
- Phase B (cnt[3]=1), on accepted sample, with a = head and b = x_in:
  - output candidate = a+b.
  - push a-b into the delay line.
- Add/sub: WIDTH-bit wrap-around, no scaling, no saturation.
- Twiddle ROM (W16^k = cos - j sin, scaled by 2^TW_FRAC, TW_FRAC=8), wr/wi per k:
  - k0: 256/0
  - k1: 237/-98
  - k2: 181/-181
  - k3: 98/-237
  - k4: 0/-256
  - k5: -98/-237
  - k6: -181/-181
  - k7: -237/-98
- Complex multiply:
  - real = dr*wr - di*wi; imag = dr*wi + di*wr, full precision.
  - Then add 2^(TW_FRAC-1), arithmetic-shift right by TW_FRAC, keep the low WIDTH bits.
- primed: set on the first accepted sample with cnt==8 and stays set until reset. Phase-A outputs before primed are suppressed (delay line holds no differences yet).
- Output register: on each accepted sample with (primed | phase B), load the candidate and set valid_o=1 next cycle; otherwise valid_o=0 next cycle and the data holds its last value.
- Latency: 1 cycle from an accepted input to its output.
- Order per 16-sample block b: s_k = x[16b+k] + x[16b+8+k] for k=0..7, emitted while x[16b+8..15] arrive; then d_k*W16^k, emitted while the next 8 samples arrive.
- Flush: the upstream driver keeps valid_i=1 with zero data for 8 cycles after the last frame sample.
- Frames are back-to-back with no gap required. Wrap 31->0 continues the same schedule.

Test Plan:
- Impulse: x0=(64,0), x1..x31=0, then 8 zero flush samples, valid_i continuous.
  - -> 32 valid outputs, first 1 cycle after x8 is accepted.
  - out[0]=64, out[8]=(64,0) (d0*W^0), all others 0.
- Constant: 32 samples of (100,0), then 8 zeros.
  - -> out[0..7]=(200,0), out[8..15]=(0,0), out[16..23]=(200,0), out[24..31]=(0,0).
- Twiddle rounding: x2=(8,0), rest 0.
  - -> out[2]=(8,0); out[10]=d2*W^2=(6,-6).
  - Check (1448+128)>>>8=6 and (-1448+128)>>>8=-6.
- Stall: repeat the constant test with valid_i deasserted for 3 cycles after sample 5 and after sample 20.
  - -> output values and order identical to the constant test.
  - valid_o low for exactly the stalled cycles.
- Mid-frame reset: assert rst_n=1 for one cycle after sample 12, then restart the impulse test.
  - -> valid_o=0 and data=0 the cycle after reset.
  - The restarted frame matches the impulse result with no residue from the aborted frame.
- Back-to-back frames: two constant frames (100 then -50), no gap.
  - -> the second frame's sums are (-100,0) and its differences (0,0).
  - No valid_o bubble at the frame boundary.

Source files
------------

// File: rtl/fft32_stage2.sv
// fft32_stage2 -- second R2SDF DIF stage of the 32-point streaming FFT.
//
// Butterflies with span 8. The difference branch is multiplied by W16^k on
// its way out of the delay line. Results go out through a registered output.
//
// Ports:
//   clk         rising-edge clock for all logic
//   rst_n       synchronous reset, ACTIVE HIGH (the name is historical)
//   valid_i     input sample valid; the block advances only on valid_i=1
//   data_in_r   real part of input sample (signed WIDTH)
//   data_in_i   imaginary part of input sample (signed WIDTH)
//   valid_o     output sample valid, one cycle after the accepted input
//   data_out_r  real part of output sample (signed WIDTH)
//   data_out_i  imaginary part of output sample (signed WIDTH)
//
// Handshake: there is no backpressure. A sample is accepted on every rising
// edge where valid_i=1. valid_o=1 marks a new output sample for exactly one
// cycle. data_out_* hold their last value while valid_o=0.
module fft32_stage2 #(
  parameter int WIDTH   = 16,
  parameter int TW_FRAC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] data_in_r,
  input  logic signed [WIDTH-1:0] data_in_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] data_out_r,
  output logic signed [WIDTH-1:0] data_out_i
);

  localparam int TW_W   = TW_FRAC + 2;
  localparam int PROD_W = WIDTH + TW_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) <<< (TW_FRAC - 1);

  logic [4:0]              cnt;
  logic                    primed;
  logic signed [WIDTH-1:0] dl_r [8];  // index 0 is the head (oldest entry)
  logic signed [WIDTH-1:0] dl_i [8];

  logic                    phase_b;
  logic [2:0]              k;
  logic signed [TW_W-1:0]  wr, wi;
  logic signed [SUM_W-1:0] hr_x, hi_x, wr_x, wi_x;
  logic signed [SUM_W-1:0] mul_r, mul_i;
  logic signed [WIDTH-1:0] tw_r, tw_i;
  logic signed [WIDTH-1:0] sum_r, sum_i, diff_r, diff_i;
  logic signed [WIDTH-1:0] cand_r, cand_i, push_r, push_i;

  assign phase_b = cnt[3];
  assign k       = cnt[2:0];

  // W16^k = cos - j sin, scaled by 2^TW_FRAC.
  always_comb begin
    wr = '0;
    wi = '0;
    case (k)
      3'd0: begin wr = TW_W'(256);  wi = TW_W'(0);    end
      3'd1: begin wr = TW_W'(237);  wi = TW_W'(-98);  end
      3'd2: begin wr = TW_W'(181);  wi = TW_W'(-181); end
      3'd3: begin wr = TW_W'(98);   wi = TW_W'(-237); end
      3'd4: begin wr = TW_W'(0);    wi = TW_W'(-256); end
      3'd5: begin wr = TW_W'(-98);  wi = TW_W'(-237); end
      3'd6: begin wr = TW_W'(-181); wi = TW_W'(-181); end
      3'd7: begin wr = TW_W'(-237); wi = TW_W'(-98);  end
      default: begin wr = '0; wi = '0; end
    endcase
  end

  // The operands are sign-extended to SUM_W, so the products and their sum
  // are exact. Rounding is half-up, then an arithmetic shift. The result is
  // truncated to WIDTH bits, which wraps it around.
  always_comb begin
    hr_x   = SUM_W'(dl_r[0]);
    hi_x   = SUM_W'(dl_i[0]);
    wr_x   = SUM_W'(wr);
    wi_x   = SUM_W'(wi);
    mul_r  = hr_x * wr_x - hi_x * wi_x;
    mul_i  = hr_x * wi_x + hi_x * wr_x;
    tw_r   = WIDTH'((mul_r + RND) >>> TW_FRAC);
    tw_i   = WIDTH'((mul_i + RND) >>> TW_FRAC);
    sum_r  = dl_r[0] + data_in_r;
    sum_i  = dl_i[0] + data_in_i;
    diff_r = dl_r[0] - data_in_r;
    diff_i = dl_i[0] - data_in_i;
  end

  // Phase A forwards the input into the delay line and emits the rotated
  // difference of the previous half-block. Phase B emits the sum and stores
  // the difference.
  always_comb begin
    cand_r = phase_b ? sum_r  : tw_r;
    cand_i = phase_b ? sum_i  : tw_i;
    push_r = phase_b ? diff_r : data_in_r;
    push_i = phase_b ? diff_i : data_in_i;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt        <= '0;
      primed     <= 1'b0;
      valid_o    <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
      for (int i = 0; i < 8; i++) begin
        dl_r[i] <= '0;
        dl_i[i] <= '0;
      end
    end else begin
      if (valid_i) begin
        cnt <= cnt + 5'd1;
        if (cnt == 5'd8) primed <= 1'b1;
        for (int i = 0; i < 7; i++) begin
          dl_r[i] <= dl_r[i+1];
          dl_i[i] <= dl_i[i+1];
        end
        dl_r[7] <= push_r;
        dl_i[7] <= push_i;
      end
      // Before the first phase B, the delay line holds no differences yet,
      // so phase-A outputs are suppressed.
      if (valid_i && (primed || phase_b)) begin
        valid_o    <= 1'b1;
        data_out_r <= cand_r;
        data_out_i <= cand_i;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft32_stage2.sv
// Testbench for fft32_stage2.
//
// The reference model keeps every sample accepted since the last reset.
// Accepted sample n with j = n mod 16 produces:
//   j >= 8           : x[n-8] + x[n]
//   j <  8, n >= 16  : (x[n-16] - x[n-8]) * W16^j, rounded
//   otherwise        : no output
module tb_fft32_stage2;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                valid_i;
  logic signed [W-1:0] data_in_r, data_in_i;
  logic                valid_o;
  logic signed [W-1:0] data_out_r, data_out_i;

  fft32_stage2 #(.WIDTH(W), .TW_FRAC(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          hist_r[$];
  int          hist_i[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] last_exp = '0;

  int tw_re[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int tw_im[8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int rnd(input int p);
    return (p + 128) >>> 8;
  endfunction

  function automatic logic [31:0] pack(input int r, input int i);
    logic [31:0] p;
    p = {r[15:0], i[15:0]};
    return p;
  endfunction

  // Drive one cycle, update the model, then check the registered output.
  task automatic step(input logic v, input int r, input int i);
    int n, j, er, ei, dr, di;
    logic ev;
    valid_i   = v;
    data_in_r = r[15:0];
    data_in_i = i[15:0];
    ev = 1'b0;
    if (v) begin
      hist_r.push_back(wrap(r));
      hist_i.push_back(wrap(i));
      n = hist_r.size() - 1;
      j = n % 16;
      if (j >= 8) begin
        er = wrap(hist_r[n-8] + hist_r[n]);
        ei = wrap(hist_i[n-8] + hist_i[n]);
        ev = 1'b1;
      end else if (n >= 16) begin
        dr = wrap(hist_r[n-16] - hist_r[n-8]);
        di = wrap(hist_i[n-16] - hist_i[n-8]);
        er = wrap(rnd(dr * tw_re[j] - di * tw_im[j]));
        ei = wrap(rnd(dr * tw_im[j] + di * tw_re[j]));
        ev = 1'b1;
      end
      if (ev) begin
        exp_q.push_back(pack(er, ei));
        last_exp = pack(er, ei);
      end
    end
    @(posedge clk);
    #1;
    check("valid_o", valid_o, ev);
    if (valid_o) begin
      obs_q.push_back({data_out_r, data_out_i});
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check("data", {data_out_r, data_out_i}, exp_q.pop_front());
    end else begin
      check("hold", {data_out_r, data_out_i}, last_exp);
    end
    exp_q.delete();
  endtask

  // Reset for one cycle with valid_i asserted, to check reset priority.
  task automatic do_reset();
    rst_n     = 1'b1;
    valid_i   = 1'b1;
    data_in_r = 16'sd777;
    data_in_i = -16'sd333;
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", {data_out_r, data_out_i}, 32'h0);
    hist_r.delete();
    hist_i.delete();
    exp_q.delete();
    obs_q.delete();
    last_exp = '0;
  endtask

  task automatic flush();
    for (int f = 0; f < 8; f++) step(1'b1, 0, 0);
  endtask

  task automatic impulse_frame();
    for (int s = 0; s < 32; s++) step(1'b1, (s == 0) ? 64 : 0, 0);
  endtask

  task automatic check_constant_obs(input string tag);
    check({tag, "_count"}, obs_q.size(), 32);
    if (obs_q.size() == 32)
      for (int o = 0; o < 32; o++)
        check(tag, obs_q[o], ((o / 8) % 2 == 0) ? pack(200, 0) : pack(0, 0));
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_i   = 1'b0;
    data_in_r = '0;
    data_in_i = '0;
    @(negedge clk);

    // reset state
    do_reset();

    // impulse
    do_reset();
    impulse_frame();
    flush();
    check("imp_count", obs_q.size(), 32);
    if (obs_q.size() == 32) begin
      check("imp_out0", obs_q[0], pack(64, 0));
      check("imp_out8", obs_q[8], pack(64, 0));
      check("imp_out1", obs_q[1], pack(0, 0));
    end

    // constant
    do_reset();
    for (int s = 0; s < 32; s++) step(1'b1, 100, 0);
    flush();
    check_constant_obs("const");

    // twiddle rounding
    do_reset();
    for (int s = 0; s < 32; s++) step(1'b1, (s == 2) ? 8 : 0, 0);
    flush();
    check("tw_count", obs_q.size(), 32);
    if (obs_q.size() == 32) begin
      check("tw_out2", obs_q[2], pack(8, 0));
      check("tw_out10", obs_q[10], pack(6, -6));
    end

    // constant with stalls; garbage data while valid_i=0
    do_reset();
    for (int s = 0; s < 32; s++) begin
      step(1'b1, 100, 0);
      if (s == 5 || s == 20)
        for (int t = 0; t < 3; t++)
          step(1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
    flush();
    check_constant_obs("stall");

    // mid-frame reset, then a clean impulse
    do_reset();
    for (int s = 0; s <= 12; s++) step(1'b1, 500 + s, -300 + s);
    do_reset();
    impulse_frame();
    flush();
    check("mrst_count", obs_q.size(), 32);
    if (obs_q.size() == 32) begin
      check("mrst_out0", obs_q[0], pack(64, 0));
      check("mrst_out8", obs_q[8], pack(64, 0));
      check("mrst_out9", obs_q[9], pack(0, 0));
    end

    // back-to-back frames
    do_reset();
    for (int s = 0; s < 32; s++) step(1'b1, 100, 0);
    for (int s = 0; s < 32; s++) step(1'b1, -50, 0);
    flush();
    check("b2b_count", obs_q.size(), 64);
    if (obs_q.size() == 64) begin
      check("b2b_out31", obs_q[31], pack(0, 0));
      check("b2b_out32", obs_q[32], pack(-100, 0));
      check("b2b_out40", obs_q[40], pack(0, 0));
      check("b2b_out48", obs_q[48], pack(-100, 0));
    end

    // random full-range data with random stalls, several frames
    do_reset();
    for (int s = 0; s < 96; s++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      step(1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
    flush();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
